// File: rtl/adder_sequencer_if.sv
// Request/result bus of adder_sequencer: two requesters in, one result channel out.
interface adder_sequencer_if #(
    parameter int unsigned NNIB = 4
);
    localparam int unsigned W = 4 * NNIB;

    logic         r0_valid;
    logic         r1_valid;
    logic [W-1:0] r0_a;
    logic [W-1:0] r0_b;
    logic [W-1:0] r1_a;
    logic [W-1:0] r1_b;
    logic         r0_cin;
    logic         r1_cin;
    logic         r0_ready;
    logic         r1_ready;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         res_id;
    logic         busy;

    modport master (
        output r0_valid, r1_valid, r0_a, r0_b, r1_a, r1_b, r0_cin, r1_cin, res_ready,
        input  r0_ready, r1_ready, res_valid, res_sum, res_cout, res_id, busy
    );

    modport slave (
        input  r0_valid, r1_valid, r0_a, r0_b, r1_a, r1_b, r0_cin, r1_cin, res_ready,
        output r0_ready, r1_ready, res_valid, res_sum, res_cout, res_id, busy
    );
endinterface

// File: rtl/adder_sequencer.sv
// Two-requester, round-robin arbitrated W-bit adder that ripples one nibble per
// cycle through a single 4-bit adder_block.
module adder_block (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);
endmodule

module adder_sequencer #(
    parameter int unsigned NNIB = 4
) (
    input logic            clk,
    input logic            rst_n,
    adder_sequencer_if.slave bus
);
    localparam int unsigned W  = 4 * NNIB;
    localparam int unsigned KW = $clog2(NNIB);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  sum_q;
    logic          carry_q;
    logic          cout_q;
    logic          id_q;
    logic          ptr_q;
    logic          valid_q;
    logic [KW-1:0] k_q;

    logic          any_req;
    logic          gnt_id;
    logic          gnt;
    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [3:0]    nib_s;
    logic          nib_co;

    // Round-robin: on a tie the requester not granted last wins.
    assign any_req = bus.r0_valid | bus.r1_valid;
    assign gnt_id  = bus.r1_valid & (~bus.r0_valid | ~ptr_q);
    assign gnt     = rst_n & (state == IDLE) & any_req;

    assign bus.r0_ready  = gnt & ~gnt_id;
    assign bus.r1_ready  = gnt & gnt_id;
    assign bus.res_valid = valid_q;
    assign bus.res_sum   = sum_q;
    assign bus.res_cout  = cout_q;
    assign bus.res_id    = id_q;
    assign bus.busy      = (state != IDLE);

    assign nib_a = 4'(a_q >> {k_q, 2'b00});
    assign nib_b = 4'(b_q >> {k_q, 2'b00});

    adder_block u_add (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_s),
        .cout (nib_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            id_q    <= 1'b0;
            ptr_q   <= 1'b1;
            valid_q <= 1'b0;
            k_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        a_q     <= gnt_id ? bus.r1_a   : bus.r0_a;
                        b_q     <= gnt_id ? bus.r1_b   : bus.r0_b;
                        carry_q <= gnt_id ? bus.r1_cin : bus.r0_cin;
                        id_q    <= gnt_id;
                        ptr_q   <= gnt_id;
                        k_q     <= '0;
                        state   <= ADD;
                    end
                end
                ADD: begin
                    sum_q[{k_q, 2'b00} +: 4] <= nib_s;
                    carry_q <= nib_co;
                    k_q     <= KW'(k_q + 1'b1);
                    if (k_q == KW'(NNIB - 1)) begin
                        cout_q  <= nib_co;
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_sequencer.sv
// Bench for adder_sequencer: directed operations checked against literals and
// against a cycle-level transaction model compared on every falling edge.
module tb_adder_sequencer;
    localparam int unsigned NNIB = 4;
    localparam int unsigned W    = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adder_sequencer_if #(.NNIB(NNIB)) bus ();

    adder_sequencer #(.NNIB(NNIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: grant -> NNIB add cycles -> result held until taken.
    bit           m_busy = 1'b0;
    bit           m_done = 1'b0;
    bit           m_ptr  = 1'b1;
    bit           m_id   = 1'b0;
    int           m_cnt  = 0;
    logic [W:0]   m_res  = '0;

    always @(negedge clk) begin
        bit e0;
        bit e1;
        if (!rst_n) begin
            check("rst_r0_ready", 64'(bus.r0_ready), 64'd0);
            check("rst_r1_ready", 64'(bus.r1_ready), 64'd0);
            check("rst_res_valid", 64'(bus.res_valid), 64'd0);
            check("rst_busy", 64'(bus.busy), 64'd0);
            check("rst_res_sum", 64'(bus.res_sum), 64'd0);
            check("rst_res_cout", 64'(bus.res_cout), 64'd0);
            check("rst_res_id", 64'(bus.res_id), 64'd0);
            m_busy = 1'b0;
            m_done = 1'b0;
            m_ptr  = 1'b1;
        end else begin
            e0 = 1'b0;
            e1 = 1'b0;
            if (!m_busy) begin
                if (bus.r0_valid && bus.r1_valid) begin
                    e0 = m_ptr;
                    e1 = !m_ptr;
                end else begin
                    e0 = bus.r0_valid;
                    e1 = bus.r1_valid;
                end
            end
            check("m_r0_ready", 64'(bus.r0_ready), 64'(e0));
            check("m_r1_ready", 64'(bus.r1_ready), 64'(e1));
            check("m_res_valid", 64'(bus.res_valid), 64'(m_done));
            check("m_busy", 64'(bus.busy), 64'(m_busy));
            if (m_done) begin
                check("m_res_sum", 64'(bus.res_sum), 64'(m_res[W-1:0]));
                check("m_res_cout", 64'(bus.res_cout), 64'(m_res[W]));
                check("m_res_id", 64'(bus.res_id), 64'(m_id));
            end
            if (!m_busy) begin
                if (e0 || e1) begin
                    m_id   = e1;
                    m_ptr  = e1;
                    m_res  = e1 ? (W+1)'(bus.r1_a) + (W+1)'(bus.r1_b) + (W+1)'(bus.r1_cin)
                                : (W+1)'(bus.r0_a) + (W+1)'(bus.r0_b) + (W+1)'(bus.r0_cin);
                    m_busy = 1'b1;
                    m_cnt  = 0;
                end
            end else if (!m_done) begin
                m_cnt++;
                if (m_cnt == NNIB) m_done = 1'b1;
            end else if (bus.res_ready) begin
                m_busy = 1'b0;
                m_done = 1'b0;
            end
        end
    end

    task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic [W-1:0] es, input logic ec, input int hold);
        int gc;
        bit got;
        if (id) begin
            bus.r1_a = a; bus.r1_b = b; bus.r1_cin = cin; bus.r1_valid = 1'b1;
        end else begin
            bus.r0_a = a; bus.r0_b = b; bus.r0_cin = cin; bus.r0_valid = 1'b1;
        end
        #1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if ((id ? bus.r1_ready : bus.r0_ready) === 1'b1) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("grant_seen", 64'(got), 64'd1);
        check("other_ready_low", 64'(id ? bus.r0_ready : bus.r1_ready), 64'd0);
        gc = cyc;
        @(posedge clk); #1;
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.res_valid === 1'b1) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("result_seen", 64'(got), 64'd1);
        check("latency", 64'(cyc - gc), 64'd5);
        check("res_sum", 64'(bus.res_sum), 64'(es));
        check("res_cout", 64'(bus.res_cout), 64'(ec));
        check("res_id", 64'(bus.res_id), 64'(id));
        for (int i = 0; i < hold; i++) begin
            bus.r1_valid = 1'b1;
            #1;
            check("hold_no_grant", 64'({bus.r0_ready, bus.r1_ready}), 64'd0);
            check("hold_valid", 64'(bus.res_valid), 64'd1);
            check("hold_sum", 64'(bus.res_sum), 64'(es));
            @(posedge clk); #1;
        end
        bus.r1_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        check("res_valid_fall", 64'(bus.res_valid), 64'd0);
        check("idle_after_take", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        bit ids [4];
        int n;
        bit got;
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
        bus.r0_a = '0; bus.r0_b = '0; bus.r0_cin = 1'b0;
        bus.r1_a = '0; bus.r1_b = '0; bus.r1_cin = 1'b0;
        bus.res_ready = 1'b0;

        @(posedge clk); #1;
        bus.r0_valid = 1'b1;
        @(posedge clk); #1;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_ready_gated", 64'(bus.r0_ready), 64'd0);
        bus.r0_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(1'b0, 16'h0007, 16'h0007, 1'b0, 16'h000E, 1'b0, 0);
        do_op(1'b1, 16'h0007, 16'h0007, 1'b1, 16'h000F, 1'b0, 0);
        do_op(1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0);
        do_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 10);

        // Both requesters valid straight out of reset: grants must alternate.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.r0_a = 16'h1234; bus.r0_b = 16'h1111; bus.r0_cin = 1'b0;
        bus.r1_a = 16'hF000; bus.r1_b = 16'h1000; bus.r1_cin = 1'b1;
        bus.r0_valid = 1'b1; bus.r1_valid = 1'b1;
        bus.res_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            #1;
            if (bus.r0_ready && bus.r1_ready) check("both_ready", 64'd1, 64'd0);
            if (bus.res_valid && bus.res_id == 1'b0)
                check("alt_sum_r0", 64'({bus.res_cout, bus.res_sum}), 64'h0_2345);
            if (bus.res_valid && bus.res_id == 1'b1)
                check("alt_sum_r1", 64'({bus.res_cout, bus.res_sum}), 64'h1_0001);
            if (bus.r0_ready || bus.r1_ready) begin
                ids[n] = bus.r1_ready;
                n++;
            end
            @(posedge clk); #1;
        end
        check("alt_grant_count", 64'(n), 64'd4);
        check("alt_order", 64'({ids[0], ids[1], ids[2], ids[3]}), 64'b0101);
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (!bus.busy) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("alt_drain", 64'(got), 64'd1);
        bus.res_ready = 1'b0;
        @(posedge clk); #1;

        // Reset during the second ADD cycle aborts the operation.
        bus.r0_a = 16'h0101; bus.r0_b = 16'h0202; bus.r0_cin = 1'b0;
        bus.r0_valid = 1'b1;
        #1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bus.r0_ready) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("abort_grant", 64'(got), 64'd1);
        @(posedge clk); #1;
        bus.r0_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", 64'({bus.busy, bus.res_valid, bus.res_cout, bus.res_id,
                                     bus.r0_ready, bus.r1_ready}), 64'd0);
        check("abort_sum", 64'(bus.res_sum), 64'd0);
        bus.r0_valid = 1'b1; bus.r1_valid = 1'b1;
        @(posedge clk); #1;
        check("abort_no_valid", 64'(bus.res_valid), 64'd0);
        rst_n = 1'b1;
        #1;
        check("post_reset_r0", 64'(bus.r0_ready), 64'd1);
        check("post_reset_r1", 64'(bus.r1_ready), 64'd0);
        @(posedge clk); #1;
        bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
        bus.res_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            if (!bus.busy) got = 1'b1;
        end
        check("post_reset_done", 64'(got), 64'd1);
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/adder_sequencer.md
ADDER_SEQUENCER -- requirements
Module: adder_sequencer

Interface
REQ-001 The block SHALL have parameter NNIB, default 4, giving the number of 4-bit nibbles per operand (operand width W = 4*NNIB); NNIB range is 2..8.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports r0_valid and r1_valid, input, 1 each, requester 0/1 has an operation pending.
REQ-005 The block SHALL have ports r0_a, r0_b, r1_a and r1_b, input, W each, operands.
REQ-006 The block SHALL have ports r0_cin and r1_cin, input, 1 each, carry-in.
REQ-007 The block SHALL have ports r0_ready and r1_ready, output, 1 each, request accepted this cycle.
REQ-008 The block SHALL have port res_valid, output, 1, result available.
REQ-009 The block SHALL have port res_ready, input, 1, consumer takes the result.
REQ-010 The block SHALL have ports res_sum (output, W, sum), res_cout (output, 1, final carry) and res_id (output, 1, requester that owns the result).
REQ-011 The block SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-012 The block SHALL instantiate exactly one adder_block (4-bit a, b, cin; 4-bit sum, cout) and perform every addition through it, one nibble per cycle, LSB nibble first.
REQ-013 The FSM SHALL have states IDLE, ADD and DONE only.
REQ-014 IDLE: when at least one rX_valid is high, the block SHALL grant one requester, pulse its rX_ready for exactly that cycle, latch its a, b and cin, clear the nibble index, and go to ADD next cycle.
REQ-015 Arbitration SHALL be round-robin. A single valid requester always wins. If both are valid, the requester not granted last wins. The last-grant pointer resets to 1, so r0 wins the first tie.
REQ-016 rX_ready SHALL be high only in IDLE, only for the granted requester, and both SHALL never be high in the same cycle.
REQ-017 ADD: each cycle the block SHALL present nibble k of the latched a and b, plus the carry register, to adder_block. It SHALL write the sum into nibble k of the result register, load cout into the carry register, and increment k.
REQ-018 In the first ADD cycle the carry register SHALL hold the latched cin.
REQ-019 After the cycle with k = NNIB-1, the FSM SHALL go to DONE. ADD SHALL last exactly NNIB cycles.
REQ-020 Latency SHALL be NNIB+1 cycles from the grant edge to res_valid rising (NNIB = 4 gives res_valid 5 cycles after the ready pulse).
REQ-021 DONE: res_valid SHALL be high; res_sum, res_cout and res_id SHALL be held stable until res_ready is sampled high.
REQ-022 When res_ready is high in DONE, the FSM SHALL go to IDLE; res_valid SHALL fall the next cycle.
REQ-023 A new grant SHALL occur no earlier than the cycle after IDLE is entered, so there is no DONE-to-grant bypass; throughput is at most one operation per NNIB+2 cycles.
REQ-024 rX_valid changes while the block is busy SHALL be ignored. Latched operands SHALL NOT change during ADD or DONE.
REQ-025 Arithmetic SHALL be unsigned modulo 2^W. res_cout SHALL be the carry out of the top nibble, i.e. {res_cout,res_sum} = a + b + cin.
REQ-026 res_ready high outside DONE SHALL have no effect.

Reset
REQ-027 Asserting rst_n low SHALL immediately force: FSM to IDLE, r0_ready = r1_ready = 0, res_valid = 0, busy = 0, res_sum = 0, res_cout = 0, res_id = 0, carry register = 0, nibble index = 0, last-grant pointer = 1.
REQ-028 Reset in ADD or DONE SHALL abort the operation with no result delivered. After release, the first grant SHALL follow REQ-015 with pointer = 1.
REQ-029 The block SHALL leave IDLE no earlier than the first rising clk edge after rst_n is released.

Verification
REQ-030 Bench SHALL cover: NNIB=4, r0 only, a=16'h0007, b=16'h0007, cin=0 -> r0_ready pulse, res_valid 5 cycles later, res_sum=16'h000E, res_cout=0, res_id=0.
REQ-031 Bench SHALL cover: r1 only, a=16'h0007, b=16'h0007, cin=1 -> res_sum=16'h000F, res_cout=0, res_id=1.
REQ-032 Bench SHALL cover: r0, a=16'hFFFF, b=16'h0001, cin=0 (carry ripples through all nibbles) -> res_sum=16'h0000, res_cout=1. Also a=16'hFFFF, b=16'hFFFF, cin=1 -> res_sum=16'hFFFF, res_cout=1.
REQ-033 Bench SHALL cover: both valid continuously after reset -> grants alternate r0, r1, r0, r1; never both ready; res_id matches each grant.
REQ-034 Bench SHALL cover: res_ready held low 10 cycles in DONE -> outputs stable, no new grant; res_ready=1 -> res_valid low next cycle, IDLE.
REQ-035 Bench SHALL cover: rst_n pulsed low in the 2nd ADD cycle -> all outputs 0 immediately, no res_valid; with both requesters valid afterwards, r0 is granted first.
